// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and the address window check
// used by the SRAM responder.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // True when addr falls inside [base, base + span_bytes).
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span_bytes);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < span_bytes);
    endfunction

endpackage

// File: rtl/sram_lat_cnt.sv
// 4-bit response-latency down-counter. With SRAM_RAND_DELAY_EN defined the load
// value comes from a free-running 16-bit LFSR instead of the fixed LATENCY.
module sram_lat_cnt #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic zero_load_o,
    output logic last_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] load_val;

`ifdef SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign load_val = lfsr_q[3:0];
`else
    assign load_val = 4'(LATENCY - 1);
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero load means the response is due on the very next cycle.
    assign zero_load_o = (load_val == 4'd0);
    assign last_o      = (cnt_q == 4'd1);

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite word-addressed SRAM responder with independent read and write FSMs.
// Optional SRAM_RAND_DELAY_EN replaces the fixed LATENCY with an LFSR-driven one.
module axil_sram_slave
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output r_state_t    r_state_o,
    output w_state_t    w_state_o
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic [31:0] mem_q [DEPTH];

    // Read path state
    r_state_t    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        r_load;
    logic        r_zero_load;
    logic        r_last;
    logic [31:0] r_cap_addr;
    logic [IDX_W-1:0] r_idx;
    logic        r_ok;

    // Write path state
    w_state_t    w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        w_load;
    logic        w_zero_load;
    logic        w_last;
    logic        aw_hs;
    logic        w_hs;
    logic [31:0] aw_eff;
    logic [31:0] wd_eff;
    logic [3:0]  ws_eff;
    logic        commit;
    logic [31:0] c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_strb;
    logic        c_ok;
    logic [IDX_W-1:0] c_idx;

    sram_lat_cnt #(.LATENCY(LATENCY)) u_r_cnt (
        .clk         (clk),
        .rst         (rst),
        .load_i      (r_load),
        .zero_load_o (r_zero_load),
        .last_o      (r_last)
    );

    sram_lat_cnt #(.LATENCY(LATENCY)) u_w_cnt (
        .clk         (clk),
        .rst         (rst),
        .load_i      (w_load),
        .zero_load_o (w_zero_load),
        .last_o      (w_last)
    );

    assign arready   = (r_state_q == R_IDLE);
    assign rvalid    = (r_state_q == R_RESP);
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign awready   = (w_state_q == W_IDLE) && !aw_held_q;
    assign wready    = (w_state_q == W_IDLE) && !w_held_q;
    assign bvalid    = (w_state_q == W_RESP);
    assign bresp     = bresp_q;
    assign r_state_o = r_state_q;
    assign w_state_o = w_state_q;

    // Capture addresses straight from the bus when the latency is a single cycle.
    always_comb begin
        r_state_d  = r_state_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        r_load     = 1'b0;
        r_cap_addr = (r_state_q == R_IDLE) ? araddr : raddr_q;
        r_ok       = addr_ok(r_cap_addr, BASE, SPAN);
        r_idx      = IDX_W'((r_cap_addr - BASE) >> 2);

        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    raddr_d = araddr;
                    r_load  = 1'b1;
                    if (r_zero_load) begin
                        rdata_d   = r_ok ? mem_q[r_idx] : 32'd0;
                        rresp_d   = r_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_last) begin
                    rdata_d   = r_ok ? mem_q[r_idx] : 32'd0;
                    rresp_d   = r_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= 32'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // AW and W are collected independently; the latency starts once both are in.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        w_load    = 1'b0;
        commit    = 1'b0;
        aw_hs     = awvalid && awready;
        w_hs      = wvalid && wready;
        aw_eff    = aw_held_q ? waddr_q : awaddr;
        wd_eff    = w_held_q ? wdata_q : wdata;
        ws_eff    = w_held_q ? wstrb_q : wstrb;
        c_addr    = waddr_q;
        c_data    = wdata_q;
        c_strb    = wstrb_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    waddr_d   = awaddr;
                    aw_held_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                    w_held_d = 1'b1;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    w_load    = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    waddr_d   = aw_eff;
                    wdata_d   = wd_eff;
                    wstrb_d   = ws_eff;
                    if (w_zero_load) begin
                        commit    = 1'b1;
                        c_addr    = aw_eff;
                        c_data    = wd_eff;
                        c_strb    = ws_eff;
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_last) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        c_ok  = addr_ok(c_addr, BASE, SPAN);
        c_idx = IDX_W'((c_addr - BASE) >> 2);
        if (commit) begin
            bresp_d = c_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Array is not reset; a reset coinciding with the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (rst && commit && c_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (c_strb[b]) begin
                    mem_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Self-checking bench for axil_sram_slave built with LATENCY=3 and default
// BASE/DEPTH; per-scenario tasks drive AXI-Lite traffic against a reference model.
module tb_axil_sram_slave;
    import axil_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    r_state_t    r_state;
    w_state_t    w_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [33:0] exp_q[$];
    logic [1:0]  exp_b_q[$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    axil_sram_slave #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .r_state_o (r_state),
        .w_state_o (w_state)
    );

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_rng(a)) return 32'd0;
        if (!model.exists(key_of(a))) return 32'd0;
        return model[key_of(a)];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        if (in_rng(a)) begin
            v = model_read(a);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            end
            model[key_of(a)] = v;
        end
    endtask

    // W is presented w_lead cycles ahead of AW (0 = same cycle).
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int w_lead);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc, lat;
        logic [1:0] eb;
        exp_b_q.push_back(in_rng(a) ? RESP_OKAY : RESP_SLVERR);
        model_write(a, d, s);
        awaddr = a; wdata = d; wstrb = s;
        wvalid = 1'b1; awvalid = (w_lead == 0);
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
            if (hs_w)  begin w_done = 1; wvalid = 1'b0; end
            if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n_tests++;
        if (!(aw_done && w_done)) begin
            n_fail++;
            $display("FAIL write_accept addr=%h aw_done=%0d w_done=%0d required both 1", a, aw_done, w_done);
        end
        lat = 1;
        while (!bvalid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL write_latency addr=%h got=%0d required=%0d", a, lat, LAT);
        end
        eb = exp_b_q.pop_front();
        n_tests++;
        if (bresp !== eb) begin
            n_fail++;
            $display("FAIL write_bresp addr=%h got=%b required=%b", a, bresp, eb);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_tests++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_release bvalid=%b awready=%b wready=%b required 0/1/1", bvalid, awready, wready);
        end
    endtask

    // rready is held low for `hold` cycles after rvalid rises.
    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed,
                            input logic [1:0] er, input int hold);
        bit done, hs;
        int cyc, lat;
        logic [33:0] e;
        exp_q.push_back({er, ed});
        araddr = a; arvalid = 1'b1;
        done = 0; cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin done = 1; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL read_accept addr=%h never accepted", a);
        end
        lat = 1;
        while (!rvalid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL read_latency addr=%h got=%0d required=%0d", a, lat, LAT);
        end
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            n_tests++;
            if (rvalid !== 1'b1 || rdata !== e[31:0] || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL read_hold cyc=%0d rvalid=%b rdata=%h arready=%b required 1/%h/0", i, rvalid, rdata, arready, e[31:0]);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (rdata !== e[31:0] || rresp !== e[33:32]) begin
            n_fail++;
            $display("FAIL read_data addr=%h got=%h/%b required=%h/%b", a, rdata, rresp, e[31:0], e[33:32]);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        n_tests++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_release rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n_tests++;
        if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready ar=%b aw=%b w=%b required 1/1/1", arready, awready, wready);
        end
        n_tests++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid rvalid=%b bvalid=%b required 0/0", rvalid, bvalid);
        end
        n_tests++;
        if (rdata !== 32'd0 || rresp !== 2'b00 || bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data rdata=%h rresp=%b bresp=%b required 0/00/00", rdata, rresp, bresp);
        end
        n_tests++;
        if (r_state !== R_IDLE || w_state !== W_IDLE) begin
            n_fail++;
            $display("FAIL reset_state r=%0d w=%0d required idle", r_state, w_state);
        end
    endtask

    task automatic test_write_read();
        axi_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0);
        axi_read(32'h8000_0010, 32'hDEADBEEF, RESP_OKAY, 0);
    endtask

    task automatic test_byte_strobe();
        axi_write(32'h8000_0020, 32'h11223344, 4'hF, 0);
        axi_write(32'h8000_0020, 32'hAABBCCDD, 4'b0101, 0);
        axi_read(32'h8000_0020, 32'h11BB33DD, RESP_OKAY, 0);
        axi_write(32'h8000_0020, 32'hFFFFFFFF, 4'b0000, 0);
        axi_read(32'h8000_0022, 32'h11BB33DD, RESP_OKAY, 0);
    endtask

    task automatic test_out_of_range();
        axi_read(32'h7FFF_FFFC, 32'd0, RESP_SLVERR, 0);
        axi_write(32'h8000_0000, 32'hCAFE0001, 4'hF, 0);
        axi_write(32'h8000_4000, 32'h55555555, 4'hF, 0);
        axi_read(32'h8000_0000, 32'hCAFE0001, RESP_OKAY, 0);
        axi_read(32'h8000_4000, 32'd0, RESP_SLVERR, 0);
        axi_write(32'h8000_3FFC, 32'h0BAD0BAD, 4'hF, 0);
        axi_read(32'h8000_3FFC, 32'h0BAD0BAD, RESP_OKAY, 0);
    endtask

    task automatic test_backpressure();
        axi_write(32'h8000_0030, 32'h5A5AA5A5, 4'hF, 0);
        axi_read(32'h8000_0030, 32'h5A5AA5A5, RESP_OKAY, 5);
    endtask

    task automatic test_channel_order();
        axi_write(32'h8000_0040, 32'h01234567, 4'hF, 2);
        axi_read(32'h8000_0040, 32'h01234567, RESP_OKAY, 0);
    endtask

    task automatic test_reset_mid_write();
        axi_write(32'h8000_0050, 32'h0BADF00D, 4'hF, 0);
        awaddr = 32'h8000_0050; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_tests++;
        if (w_state !== W_WAIT) begin
            n_fail++;
            $display("FAIL midwr_state got=%0d required=%0d", w_state, W_WAIT);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL midwr_reset bvalid=%b awready=%b wready=%b required 0/1/1", bvalid, awready, wready);
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midwr_no_b bvalid=%b required 0", bvalid);
        end
        axi_read(32'h8000_0050, 32'h0BADF00D, RESP_OKAY, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int i = 0; i < 8; i++) begin
            a = 32'h8000_0100 + 32'($urandom_range(0, 7) * 4);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 2));
            axi_read(a, model_read(a), RESP_OKAY, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_out_of_range();
        test_backpressure();
        test_channel_order();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_sram_slave.md
Name: axil_sram_slave

Overview:
- Memory-side responder for the core's instruction-fetch and load/store paths, converted to AXI4-Lite.
- Holds a word-addressed SRAM array and answers read (AR/R) and write (AW/W/B) transactions after a programmable latency.
- IFU and LSU initiators connect to it directly, or through an arbiter, in the multi-cycle NPC.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words; power of two.
- LATENCY, 1, cycles from address acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (rst==0 at posedge):
  - Read FSM goes to R_IDLE; write FSM goes to W_IDLE; counters clear.
  - arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - SRAM contents are not cleared.
  - Reset mid-transaction aborts it. A pending write whose commit has not occurred is dropped.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On arvalid, latch araddr, load counter with LATENCY-1, go to R_WAIT. If LATENCY==1, go straight to R_RESP.
  - R_WAIT: arready=0. Counter decrements each cycle. When it reaches 0, capture rdata/rresp and go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp stay stable until rready. On rvalid&&rready, go to R_IDLE next cycle.
  - Throughput: at most one outstanding read. A new AR is accepted no earlier than the cycle after the R handshake.
  - Addresses: index = (addr-BASE)>>2. addr[1:0] is ignored, so accesses are word-aligned.
  - If addr<BASE or addr>=BASE+4*DEPTH: rresp=2'b10 and rdata=0.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: awready and wready are independent. AW and W may arrive in either order or in the same cycle.
  - Each accepted channel latches its payload and drops its ready. Once both are held, load the counter and go to W_WAIT.
  - W_WAIT: when the counter reaches 0, commit the write and go to W_RESP.
    - Only bytes with wstrb[i]=1 are written.
    - An out-of-range address commits nothing and sets bresp=10.
    - wstrb==0 is legal: no change, bresp=OKAY.
  - W_RESP: bvalid=1 until bready. Then return to W_IDLE and reassert both readies.
- Simultaneous read and write:
  - The two FSMs are fully independent.
  - If a read capture and a write commit hit the same word in the same cycle, the read returns the old data (read-before-write).
- Handshake rules:
  - Outputs never depend combinationally on valid/ready inputs; all are registered.
  - Once asserted, rvalid and bvalid are held until their handshake completes.

Optional Feature:
- Macro: SRAM_RAND_DELAY_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
  - Each accepted transaction loads its counter with LFSR[3:0]. The effective latency is therefore 1..16, and LATENCY is ignored.
- Undefined: fixed LATENCY only; no LFSR logic is present.

Decomposition:
- Shared package axil_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Enum r_state_t {R_IDLE,R_WAIT,R_RESP}.
  - Enum w_state_t {W_IDLE,W_WAIT,W_RESP}.
- Sub-module sram_lat_cnt: a 4-bit down-counter with load/done. It is instantiated once per FSM and contains the LFSR when SRAM_RAND_DELAY_EN is defined.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, then release.
  - Required: arready=awready=wready=1, rvalid=bvalid=0.
- Write then read, LATENCY=3:
  - Write 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF.
  - Required: bvalid rises 3 cycles after the second of AW/W is accepted, bresp=00.
  - Then read the same address. Required: rdata=32'hDEADBEEF, rresp=00.
- Byte strobe:
  - Preload 32'h11223344, then write 32'hAABBCCDD with wstrb=4'b0101.
  - Required: read returns 32'h11BB33DD.
- Out of range:
  - Read 32'h7FFF_FFFC. Required: rresp=10, rdata=0.
  - Write 32'h8000_4000 (DEPTH=4096). Required: bresp=10, memory unchanged.
- Backpressure and channel order:
  - Hold rready=0 for 5 cycles. Required: rvalid and rdata stable, arready=0 throughout.
  - Present W 2 cycles before AW. Required: write completes correctly.
- Reset mid-write:
  - Assert rst=0 while in W_WAIT.
  - Required: bvalid=0 next cycle, and a subsequent read of that address returns the old value.
